// File: rtl/wb_regfile.sv
// Writeback-side register file with a busy-bit scoreboard for decode hazard stalls.
// BYPASS selects write-first forwarding of same-cycle writeback data to reads and stall logic.
module wb_regfile #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    input  logic        IssueD,
    input  logic [4:0]  RdD,
    output logic        StallD
);

    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];
    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic        wr_en;
    logic        issue_ok;

    // A writeback that is visible this cycle; always false without forwarding.
    function automatic logic hit_w(input logic we, input logic [4:0] rd, input logic [4:0] idx);
        return BYPASS && we && (rd == idx) && (idx != 5'd0);
    endfunction

    assign wr_en    = RegWriteW && (RdW != 5'd0);
    assign issue_ok = IssueD && !StallD && (RdD != 5'd0);

    always_comb begin
        StallD = (busy_q[A1] && !hit_w(RegWriteW, RdW, A1))
               || (busy_q[A2] && !hit_w(RegWriteW, RdW, A2))
               || (IssueD && busy_q[RdD] && !hit_w(RegWriteW, RdW, RdD));
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (A1 != 5'd0) RD1 = hit_w(RegWriteW, RdW, A1) ? ResultW : regs_q[A1];
        if (A2 != 5'd0) RD2 = hit_w(RegWriteW, RdW, A2) ? ResultW : regs_q[A2];
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[RdW] = ResultW;
    end

    // The set is applied after the clear so a new producer wins over a retiring one.
    always_comb begin
        busy_d = busy_q;
        if (wr_en)    busy_d[RdW] = 1'b0;
        if (issue_ok) busy_d[RdD] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: the register array is reset too, because reads after reset must return zero;
    // sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: both BYPASS variants run on shared stimulus against an array-based model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [4:0]  A1, A2, RdD;
    logic        IssueD;
    logic [31:0] rd1 [2];
    logic [31:0] rd2 [2];
    logic        stall [2];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state, index 0 = BYPASS off, 1 = BYPASS on.
    logic [31:0] m_reg  [2][32];
    bit          m_busy [2][32];

    always #5 clk = ~clk;

    wb_regfile #(.BYPASS(1'b0)) u_nb (
        .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .A1(A1), .A2(A2), .RD1(rd1[0]), .RD2(rd2[0]),
        .IssueD(IssueD), .RdD(RdD), .StallD(stall[0])
    );

    wb_regfile #(.BYPASS(1'b1)) u_by (
        .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .A1(A1), .A2(A2), .RD1(rd1[1]), .RD2(rd2[1]),
        .IssueD(IssueD), .RdD(RdD), .StallD(stall[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit fresh(int b, logic [4:0] x);
        return (b == 1) && RegWriteW && (RdW == x) && (x != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(int b, logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (fresh(b, a)) return ResultW;
        return m_reg[b][a];
    endfunction

    function automatic bit m_stall(int b);
        bit w1 = m_busy[b][A1] && !fresh(b, A1);
        bit w2 = m_busy[b][A2] && !fresh(b, A2);
        bit w3 = IssueD && m_busy[b][RdD] && !fresh(b, RdD);
        return w1 || w2 || w3;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 32; r++) begin
                m_reg[b][r]  = 32'h0;
                m_busy[b][r] = 1'b0;
            end
    endtask

    // Compare both DUTs against the model, clock once, then advance the model.
    task automatic step();
        bit st [2];
        #2;
        for (int b = 0; b < 2; b++) begin
            st[b] = m_stall(b);
            check($sformatf("rd1[b%0d]", b), rd1[b], m_read(b, A1));
            check($sformatf("rd2[b%0d]", b), rd2[b], m_read(b, A2));
            check($sformatf("stall[b%0d]", b), {31'h0, stall[b]}, {31'h0, st[b]});
        end
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (RegWriteW && RdW != 5'd0) begin
                    m_reg[b][RdW]  = ResultW;
                    m_busy[b][RdW] = 1'b0;
                end
                if (IssueD && !st[b] && RdD != 5'd0) m_busy[b][RdD] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; RegWriteW = 0; RdW = 0; ResultW = 0;
        A1 = 0; A2 = 0; IssueD = 0; RdD = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        model_clear();
        @(negedge clk);
        step();
        rst = 0;

        // Reset state, then a plain write becomes readable next cycle.
        A1 = 5; A2 = 0;
        #1;
        check("reset_rd1", rd1[1], 32'h0);
        check("reset_rd2", rd2[1], 32'h0);
        check("reset_stall", {31'h0, stall[1]}, 32'h0);
        step();
        RegWriteW = 1; RdW = 5; ResultW = 32'hDEADBEEF;
        step();
        RegWriteW = 0;
        #1;
        check("x5_nb", rd1[0], 32'hDEADBEEF);
        check("x5_by", rd1[1], 32'hDEADBEEF);
        step();

        // x0 is never written and never marked busy.
        RegWriteW = 1; RdW = 0; ResultW = 32'h1234; IssueD = 1; RdD = 0; A1 = 0;
        step();
        idle();
        IssueD = 1; RdD = 0;
        #1;
        check("x0_read", rd1[1], 32'h0);
        check("x0_busy", {31'h0, stall[0]}, 32'h0);
        step();
        idle();

        // Forwarding versus pre-write value on a same-cycle writeback.
        RegWriteW = 1; RdW = 7; ResultW = 32'h11;
        step();
        ResultW = 32'h22; A1 = 7;
        #1;
        check("fwd_by", rd1[1], 32'h22);
        check("fwd_nb_old", rd1[0], 32'h11);
        step();
        RegWriteW = 0;
        #1;
        check("fwd_nb_new", rd1[0], 32'h22);
        step();
        idle();

        // RAW stall released by writeback (a cycle later without forwarding).
        IssueD = 1; RdD = 3;
        step();
        IssueD = 0; A2 = 3;
        #1;
        check("raw_stall_nb", {31'h0, stall[0]}, 32'h1);
        check("raw_stall_by", {31'h0, stall[1]}, 32'h1);
        step();
        RegWriteW = 1; RdW = 3; ResultW = 32'h33;
        #1;
        check("raw_hit_by", {31'h0, stall[1]}, 32'h0);
        check("raw_hit_nb", {31'h0, stall[0]}, 32'h1);
        step();
        RegWriteW = 0;
        #1;
        check("raw_clear", {31'h0, stall[1]}, 32'h0);
        check("raw_data", rd2[0], 32'h33);
        step();
        idle();

        // Set wins over clear; a second issue to the same register stalls.
        IssueD = 1; RdD = 9; RegWriteW = 1; RdW = 9; ResultW = 32'h99;
        step();
        RegWriteW = 0;
        #1;
        check("waw_stall_nb", {31'h0, stall[0]}, 32'h1);
        check("waw_stall_by", {31'h0, stall[1]}, 32'h1);
        step();
        IssueD = 0; A1 = 9;
        #1;
        check("waw_busy_kept", {31'h0, stall[1]}, 32'h1);
        step();
        RegWriteW = 1; RdW = 9; ResultW = 32'h98; A1 = 0;
        step();
        idle();
        step();

        // Reset drops pending producers and register contents.
        IssueD = 1; RdD = 4; RegWriteW = 1; RdW = 4; ResultW = 32'hA5;
        step();
        idle();
        rst = 1; IssueD = 1; RdD = 6; RegWriteW = 1; RdW = 6; ResultW = 32'h66;
        step();
        idle();
        A1 = 4; A2 = 6;
        #1;
        check("rst_rd1", rd1[1], 32'h0);
        check("rst_rd2", rd2[0], 32'h0);
        check("rst_stall_nb", {31'h0, stall[0]}, 32'h0);
        check("rst_stall_by", {31'h0, stall[1]}, 32'h0);
        step();

        // Random traffic on a narrow index range to force hazards and collisions.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            RegWriteW = ($urandom_range(0, 99) < 45);
            RdW       = 5'($urandom_range(0, 7));
            ResultW   = $urandom;
            A1        = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            A2        = 5'($urandom_range(0, 7));
            IssueD    = ($urandom_range(0, 99) < 40);
            RdD       = 5'($urandom_range(0, 7));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: BYPASS, 1, when 1 a same-cycle writeback is forwarded to read ports (write-first); when 0 reads return the pre-write value.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: RegWriteW  input  1  writeback enable from writeback stage.
REQ-005 Port: RdW  input  5  writeback destination register index.
REQ-006 Port: ResultW  input  32  writeback data (selected ALU result / load data).
REQ-007 Port: A1  input  5  decode read address, source 1.
REQ-008 Port: A2  input  5  decode read address, source 2.
REQ-009 Port: RD1  output  32  read data for A1.
REQ-010 Port: RD2  output  32  read data for A2.
REQ-011 Port: IssueD  input  1  decode issuing an instruction that will write RdD.
REQ-012 Port: RdD  input  5  destination index of the issuing instruction.
REQ-013 Port: StallD  output  1  decode must hold; issue not accepted.

Function
REQ-014 Storage: 31 x 32-bit registers x1..x31; x0 not stored, reads of index 0 SHALL return 32'h0 regardless of any write.
REQ-015 Write: on rising edge, if RegWriteW=1 and RdW!=0 and rst=0, reg[RdW] <= ResultW; RdW=0 writes discarded.
REQ-016 Reads combinational from A1/A2; zero added latency.
REQ-017 BYPASS=1: if RegWriteW=1, RdW!=0, RdW==A1 (A2) in same cycle, RD1 (RD2) SHALL equal ResultW.
REQ-018 BYPASS=0: same-cycle read returns old value; new value visible next cycle.
REQ-019 Scoreboard: 32 busy bits, busy[0] hardwired 0.
REQ-020 Set: on rising edge, if IssueD=1, StallD=0, RdD!=0 -> busy[RdD] <= 1.
REQ-021 Clear: on rising edge, if RegWriteW=1, RdW!=0 -> busy[RdW] <= 0.
REQ-022 Simultaneous set and clear of same index in one cycle: set wins (busy stays 1, newer producer pending).
REQ-023 StallD = (busy[A1] & !hitW(A1)) | (busy[A2] & !hitW(A2)) | (IssueD & busy[RdD] & !hitW(RdD)), where hitW(x) = RegWriteW & RdW==x & x!=0; combinational.
REQ-024 hitW term applies only when BYPASS=1; with BYPASS=0 hitW is treated as 0 (stall one extra cycle).
REQ-025 IssueD with StallD=1 SHALL not modify busy bits (WAW guard: at most one pending producer per register).
REQ-026 RegWriteW to a non-busy register is legal (e.g. register written without scoreboard issue); data written, busy unchanged at 0.

Reset
REQ-027 rst=1 at rising edge: all registers <= 0, all busy bits <= 0; writes and issues in that cycle ignored.
REQ-028 Reset mid-operation discards all pending producers; after reset RD1=RD2=0 and StallD=0 for any A1/A2 with IssueD=0.
REQ-029 Reset takes precedence over every other update in the same cycle.

Verification
REQ-030 Reset then A1=5, A2=0 -> RD1=0, RD2=0, StallD=0; write x5=32'hDEADBEEF -> next cycle RD1=32'hDEADBEEF.
REQ-031 RegWriteW=1, RdW=0, ResultW=32'h1234 -> A1=0 reads 0 thereafter; busy[0] never set by IssueD, RdD=0.
REQ-032 BYPASS=1: x7=32'h11, same cycle RegWriteW RdW=7 ResultW=32'h22, A1=7 -> RD1=32'h22 that cycle; BYPASS=0 -> RD1=32'h11 that cycle, 32'h22 next.
REQ-033 Issue RdD=3; next cycle A2=3 -> StallD=1; cycle with RegWriteW RdW=3 -> StallD=0 (BYPASS=1), busy[3]=0 after edge.
REQ-034 Same edge IssueD RdD=9 and RegWriteW RdW=9 -> busy[9]=1 after edge; second IssueD RdD=9 -> StallD=1, busy unchanged.
REQ-035 Issue RdD=4, write x4=32'hA5, assert rst for one cycle -> busy[4]=0, RD(x4)=0, StallD=0.
